// File: rtl/range_merger.sv
// Insertion-sorts incoming inclusive ID ranges, merges overlaps and streams the disjoint result with a running ID total.
// Define RANGE_MERGER_ADJ_EN to also fuse adjacent ranges (e.g. 1-2 and 3-4).
module range_merger #(
  parameter int W          = 64,
  parameter int MAX_RANGES = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_start,
  input  logic [W-1:0] in_end,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_start,
  output logic [W-1:0] out_end,
  output logic         out_last,
  output logic [W:0]   total,
  output logic         done,
  output logic         err,
  output logic         overflow
);

  localparam int CW = $clog2(MAX_RANGES + 1);
  localparam int AW = (MAX_RANGES > 1) ? $clog2(MAX_RANGES) : 1;
  localparam logic [CW-1:0] FULL_N = CW'(MAX_RANGES);
  localparam logic [CW-1:0] ONE_N  = CW'(1);
  localparam logic [W:0]    ONE_T  = (W+1)'(1);

  localparam logic [2:0] S_LOAD   = 3'd0;
  localparam logic [2:0] S_INSERT = 3'd1;
  localparam logic [2:0] S_MERGE  = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [W-1:0] buf_start [MAX_RANGES];
  logic [W-1:0] buf_end   [MAX_RANGES];

  logic [2:0]    state_reg;
  logic [CW-1:0] n_reg, k_reg, i_reg;
  logic [W-1:0]  new_start_reg, new_end_reg, cur_start_reg, cur_end_reg;
  logic          last_seen_reg, scan_init_reg;
  logic          in_ready_reg, out_valid_reg, out_last_reg;
  logic [W-1:0]  out_start_reg, out_end_reg;
  logic [W:0]    total_reg;
  logic          done_reg, err_reg, overflow_reg;

  logic [CW-1:0] k_m1;
  logic [AW-1:0] prev_addr, scan_addr;
  logic [W-1:0]  prev_start, prev_end, scan_start, scan_end, head_start, head_end;
  logic          shift, merge_hit, beat_bad, beat_full;

  assign k_m1       = k_reg - ONE_N;
  assign prev_addr  = k_m1[AW-1:0];
  assign scan_addr  = i_reg[AW-1:0];
  assign prev_start = buf_start[prev_addr];
  assign prev_end   = buf_end[prev_addr];
  assign scan_start = buf_start[scan_addr];
  assign scan_end   = buf_end[scan_addr];
  assign head_start = buf_start[0];
  assign head_end   = buf_end[0];

  // Strict compare keeps equal starts in arrival order.
  assign shift     = (k_reg != '0) && (prev_start > new_start_reg);
  assign beat_bad  = in_start > in_end;
  assign beat_full = n_reg == FULL_N;

`ifdef RANGE_MERGER_ADJ_EN
  // Widened so an all-ones end plus one does not wrap to zero.
  assign merge_hit = {1'b0, scan_start} <= ({1'b0, cur_end_reg} + ONE_T);
`else
  assign merge_hit = scan_start <= cur_end_reg;
`endif

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_start, wr_end;

  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = k_reg[AW-1:0];
    wr_start = new_start_reg;
    wr_end   = new_end_reg;
    if (state_reg == S_INSERT && !rst) begin
      wr_en = 1'b1;
      if (shift) begin
        wr_start = prev_start;
        wr_end   = prev_end;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_start[wr_addr] <= wr_start;
      buf_end[wr_addr]   <= wr_end;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_LOAD;
      n_reg         <= '0;
      k_reg         <= '0;
      i_reg         <= '0;
      new_start_reg <= '0;
      new_end_reg   <= '0;
      cur_start_reg <= '0;
      cur_end_reg   <= '0;
      last_seen_reg <= 1'b0;
      scan_init_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_start_reg <= '0;
      out_end_reg   <= '0;
      total_reg     <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_LOAD: begin
          in_ready_reg <= 1'b1;
          if (in_valid && in_ready_reg) begin
            if (in_last) last_seen_reg <= 1'b1;
            if (beat_bad) err_reg <= 1'b1;
            else if (beat_full) overflow_reg <= 1'b1;
            if (!beat_bad && !beat_full) begin
              new_start_reg <= in_start;
              new_end_reg   <= in_end;
              k_reg         <= n_reg;
              in_ready_reg  <= 1'b0;
              state_reg     <= S_INSERT;
            end else if (in_last) begin
              in_ready_reg <= 1'b0;
              if (n_reg == '0) begin
                done_reg  <= 1'b1;
                state_reg <= S_DONE;
              end else begin
                scan_init_reg <= 1'b1;
                state_reg     <= S_MERGE;
              end
            end
          end
        end
        S_INSERT: begin
          if (shift) begin
            k_reg <= k_m1;
          end else begin
            n_reg <= n_reg + ONE_N;
            if (last_seen_reg) begin
              scan_init_reg <= 1'b1;
              state_reg     <= S_MERGE;
            end else begin
              in_ready_reg <= 1'b1;
              state_reg    <= S_LOAD;
            end
          end
        end
        S_MERGE: begin
          if (scan_init_reg) begin
            cur_start_reg <= head_start;
            cur_end_reg   <= head_end;
            i_reg         <= ONE_N;
            scan_init_reg <= 1'b0;
          end else if (i_reg < n_reg && merge_hit) begin
            if (scan_end > cur_end_reg) cur_end_reg <= scan_end;
            i_reg <= i_reg + ONE_N;
          end else begin
            out_valid_reg <= 1'b1;
            out_start_reg <= cur_start_reg;
            out_end_reg   <= cur_end_reg;
            out_last_reg  <= (i_reg == n_reg);
            state_reg     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            total_reg     <= total_reg + (({1'b0, out_end_reg} - {1'b0, out_start_reg}) + ONE_T);
            if (out_last_reg) begin
              done_reg  <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              cur_start_reg <= scan_start;
              cur_end_reg   <= scan_end;
              i_reg         <= i_reg + ONE_N;
              state_reg     <= S_MERGE;
            end
          end
        end
        S_DONE: ;
        default: state_reg <= S_LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_start = out_start_reg;
  assign out_end   = out_end_reg;
  assign out_last  = out_last_reg;
  assign total     = total_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_range_merger.sv
// Self-checking bench for range_merger: directed vector table, random loads against an interval-union model,
// plus backpressure and mid-emit reset sequences.
module tb_range_merger;
  localparam int W      = 64;
  localparam int TB_MAX = 4;
  localparam logic [W-1:0] ALL1 = '1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_start = '0;
  logic [W-1:0] in_end = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_start, out_end;
  logic         out_last;
  logic [W:0]   total;
  logic         done, err, overflow;

  always #5 clk = ~clk;

  range_merger #(.W(W), .MAX_RANGES(TB_MAX)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_start(in_start), .in_end(in_end), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_start(out_start), .out_end(out_end), .out_last(out_last),
    .total(total), .done(done), .err(err), .overflow(overflow)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] bs[$], be[$];
  logic [W-1:0] es[$], ee[$];
  logic [W:0]   exp_tot;
  logic         exp_err, exp_ov;
  logic [W-1:0] gs[$], ge[$];
  logic         gl[$];

  typedef struct {
    int                  nb;
    logic [0:4][W-1:0]   s;
    logic [0:4][W-1:0]   e;
    int                  no;
    logic [0:2][W-1:0]   os;
    logic [0:2][W-1:0]   oe;
    logic [W:0]          tot;
    logic                er;
    logic                ov;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ":flags"}, {in_ready, out_valid, out_last, done, err, overflow}, 0);
    chk({tag, ":out_start"}, out_start, 0);
    chk({tag, ":out_end"}, out_end, 0);
    chk({tag, ":total"}, total, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();
    chk("in_ready_after_rst", in_ready, 1);
  endtask

  task automatic send_beat(input logic [W-1:0] s, input logic [W-1:0] e, input logic l);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      step();
      cyc++;
    end
    if (!in_ready) begin
      chk("in_ready_wait", in_ready, 1);
    end else begin
      in_start = s;
      in_end   = e;
      in_last  = l;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic collect(input bit rnd);
    int cyc;
    logic pv, pr;
    logic [W-1:0] ps, pe;
    cyc = 0;
    pv = 1'b0;
    pr = 1'b0;
    ps = '0;
    pe = '0;
    gs.delete();
    ge.delete();
    gl.delete();
    while (!done && cyc < 500) begin
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_start", out_start, ps);
        chk("hold_end", out_end, pe);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        gs.push_back(out_start);
        ge.push_back(out_end);
        gl.push_back(out_last);
      end
      pv = out_valid;
      pr = out_ready;
      ps = out_start;
      pe = out_end;
      step();
      cyc++;
    end
    out_ready = 1'b1;
    chk("done", done, 1);
  endtask

  task automatic compare(input string name);
    chk({name, ":count"}, (W+1)'(gs.size()), (W+1)'(es.size()));
    for (int i = 0; i < es.size(); i++) begin
      if (i < gs.size()) begin
        chk($sformatf("%s:start%0d", name, i), gs[i], es[i]);
        chk($sformatf("%s:end%0d", name, i), ge[i], ee[i]);
        chk($sformatf("%s:last%0d", name, i), gl[i], (i == es.size() - 1) ? 1 : 0);
      end
    end
    chk({name, ":total"}, total, exp_tot);
    chk({name, ":err"}, err, exp_err);
    chk({name, ":overflow"}, overflow, exp_ov);
    chk({name, ":idle_after_done"}, out_valid, 0);
    $display("case %s: beats=%0d outputs=%0d total=%0d err=%0b overflow=%0b",
             name, bs.size(), gs.size(), total, err, overflow);
  endtask

  task automatic run_current(input string name, input bit rnd);
    do_reset();
    for (int j = 0; j < bs.size(); j++) send_beat(bs[j], be[j], j == bs.size() - 1);
    collect(rnd);
    compare(name);
  endtask

  // Reference: keep the first TB_MAX well-formed ranges, sort by start, then take their union.
  task automatic model();
    logic [W-1:0] ks[$], ke[$];
    logic [W-1:0] cs, ce, t;
    bit touch;
    es.delete();
    ee.delete();
    exp_tot = '0;
    exp_err = 1'b0;
    exp_ov  = 1'b0;
    for (int j = 0; j < bs.size(); j++) begin
      if (bs[j] > be[j]) exp_err = 1'b1;
      else if (ks.size() == TB_MAX) exp_ov = 1'b1;
      else begin
        ks.push_back(bs[j]);
        ke.push_back(be[j]);
      end
    end
    for (int a = 0; a < ks.size(); a++) begin
      for (int b = 0; b + 1 < ks.size() - a; b++) begin
        if (ks[b] > ks[b+1]) begin
          t = ks[b]; ks[b] = ks[b+1]; ks[b+1] = t;
          t = ke[b]; ke[b] = ke[b+1]; ke[b+1] = t;
        end
      end
    end
    if (ks.size() > 0) begin
      cs = ks[0];
      ce = ke[0];
      for (int j = 1; j < ks.size(); j++) begin
`ifdef RANGE_MERGER_ADJ_EN
        touch = ({1'b0, ks[j]} <= ({1'b0, ce} + 65'd1));
`else
        touch = (ks[j] <= ce);
`endif
        if (touch) begin
          if (ke[j] > ce) ce = ke[j];
        end else begin
          es.push_back(cs);
          ee.push_back(ce);
          cs = ks[j];
          ce = ke[j];
        end
      end
      es.push_back(cs);
      ee.push_back(ce);
    end
    for (int j = 0; j < es.size(); j++) exp_tot += ({1'b0, ee[j]} - {1'b0, es[j]}) + 65'd1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [W-1:0] s, e, t;

    tv[0] = '{4, '{3, 10, 16, 12, 0}, '{5, 14, 20, 18, 0}, 2, '{3, 10, 0}, '{5, 20, 0}, 14, 0, 0};
`ifdef RANGE_MERGER_ADJ_EN
    tv[1] = '{2, '{1, 3, 0, 0, 0}, '{2, 4, 0, 0, 0}, 1, '{1, 0, 0}, '{4, 0, 0}, 4, 0, 0};
`else
    tv[1] = '{2, '{1, 3, 0, 0, 0}, '{2, 4, 0, 0, 0}, 2, '{1, 3, 0}, '{2, 4, 0}, 4, 0, 0};
`endif
    tv[2] = '{3, '{7, 9, 1, 0, 0}, '{9, 2, 1, 0, 0}, 2, '{1, 7, 0}, '{1, 9, 0}, 4, 1, 0};
    tv[3] = '{5, '{20, 1, 10, 2, 30}, '{25, 3, 12, 8, 31}, 3, '{1, 10, 20}, '{8, 12, 25}, 17, 0, 1};
    tv[4] = '{1, '{9, 0, 0, 0, 0}, '{2, 0, 0, 0, 0}, 0, '{0, 0, 0}, '{0, 0, 0}, 0, 1, 0};
    tv[5] = '{3, '{5, 5, 5, 0, 0}, '{6, 9, 5, 0, 0}, 1, '{5, 0, 0}, '{9, 0, 0}, 5, 0, 0};
    tv[6] = '{2, '{20, 10, 0, 0, 0}, '{30, ALL1, 0, 0, 0}, 1, '{10, 0, 0}, '{ALL1, 0, 0},
              65'h0_FFFF_FFFF_FFFF_FFF6, 0, 0};
    tv[7] = '{2, '{ALL1 - 1, 0, 0, 0, 0}, '{ALL1, 0, 0, 0, 0}, 2, '{0, ALL1 - 1, 0}, '{0, ALL1, 0}, 3, 0, 0};

    for (int v = 0; v < 8; v++) begin
      bs.delete(); be.delete(); es.delete(); ee.delete();
      for (int j = 0; j < tv[v].nb; j++) begin
        bs.push_back(tv[v].s[j]);
        be.push_back(tv[v].e[j]);
      end
      for (int j = 0; j < tv[v].no; j++) begin
        es.push_back(tv[v].os[j]);
        ee.push_back(tv[v].oe[j]);
      end
      exp_tot = tv[v].tot;
      exp_err = tv[v].er;
      exp_ov  = tv[v].ov;
      run_current($sformatf("vec%0d", v), 1'b0);
    end

    // Backpressure on the first output.
    do_reset();
    out_ready = 1'b0;
    send_beat(3, 5, 1'b0);
    send_beat(10, 14, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 50) begin step(); cyc++; end
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_start", out_start, 3);
      chk("bp_end", out_end, 5);
      chk("bp_total_held", total, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_total_after_hs", total, 3);
    collect(1'b0);
    chk("bp_total_final", total, 8);
    $display("case backpressure: total=%0d done=%0b", total, done);

    // Reset while an output is pending, then the full-width range.
    do_reset();
    out_ready = 1'b0;
    send_beat(9, 2, 1'b0);
    send_beat(1, 2, 1'b0);
    send_beat(5, 6, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 50) begin step(); cyc++; end
    chk("rst_pre_valid", out_valid, 1);
    rst = 1'b1;
    step();
    chk_reset_outputs("mid_emit_rst");
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("in_ready_after_mid_rst", in_ready, 1);
    bs.delete(); be.delete();
    bs.push_back('0); be.push_back(ALL1);
    send_beat('0, ALL1, 1'b1);
    collect(1'b0);
    es.delete(); ee.delete();
    es.push_back('0); ee.push_back(ALL1);
    exp_tot = 65'h1_0000_0000_0000_0000;
    exp_err = 1'b0;
    exp_ov  = 1'b0;
    compare("full_range");

    for (int it = 0; it < 40; it++) begin
      bs.delete(); be.delete();
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
        s = W'($urandom_range(0, 40));
        e = s + W'($urandom_range(0, 6));
        if ($urandom_range(0, 9) == 0 && e != s) begin t = s; s = e; e = t; end
        bs.push_back(s);
        be.push_back(e);
      end
      model();
      run_current($sformatf("rand%0d", it), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
